dm_uart_dumper: RTL
===================

Name: dm_uart_dumper

Overview:
- Debug reader for the data-memory inspection port of the single-cycle processor top.
- On a start request, it sweeps addr_on_dm over every data-memory word and samples data_on_dm for each one.
- It streams the words out over a UART TX line (8N1) as a framed dump: header, data bytes, checksum.
- It sits beside the processor top on the FPGA, with addr_on_dm/data_on_dm wired point-to-point, so memory contents can be read by a host without halting the core.

Parameters:
- DM_ADDR_W, 4, data-memory address width; dump length is 2**DM_ADDR_W words.
- DM_DATA_W, 8, data-memory word width; must equal the UART byte width (8).
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 2.
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, single-cycle request to begin a dump frame.
- addr_on_dm, output, DM_ADDR_W, address driven to the data-memory debug read port.
- data_on_dm, input, DM_DATA_W, combinational read data returned for addr_on_dm.
- tx, output, 1, UART serial output, idle high.
- busy, output, 1, high from the cycle after start is accepted until the stop bit of the checksum byte ends.
- done, output, 1, one-cycle pulse when the frame completes.

Behaviour:
- Interface rules:
  - One clock: clk. Reset is synchronous and active-high on the port named reset.
  - All outputs are registered.
- Reset values:
  - tx=1, addr_on_dm=0, busy=0, done=0.
  - FSM in IDLE, checksum=0.
- Reset mid-frame: all of the above takes effect on the next clk edge. The partial frame is abandoned and tx returns high immediately. There is no resume.
- Frame format: HEADER_BYTE, then word[0]..word[2**DM_ADDR_W-1], then CHECKSUM. That is 18 bytes at default parameters.
  - CHECKSUM = sum of the data bytes only, modulo 256. The header is excluded, and carries are discarded.
- Top FSM states: IDLE, SEND_HDR, SET_ADDR, SAMPLE, SEND_DATA, SEND_SUM, FINISH.
  - IDLE: when start=1, go to SEND_HDR; busy=1 next cycle.
  - SEND_HDR: pulse tx_start with HEADER_BYTE. Wait for tx_done, then go to SET_ADDR with addr_on_dm=0.
  - SET_ADDR: hold addr_on_dm for one cycle so the combinational read settles. Go to SAMPLE.
  - SAMPLE: latch data_on_dm into the byte register and add it to the checksum. Go to SEND_DATA.
  - SEND_DATA: pulse tx_start with the latched byte and wait for tx_done.
    - If addr_on_dm is the last address, go to SEND_SUM.
    - Otherwise increment addr_on_dm and go to SET_ADDR.
  - SEND_SUM: transmit the checksum, wait for tx_done, go to FINISH.
  - FINISH: done=1 for one cycle; busy=0, addr_on_dm=0, checksum cleared. Go to IDLE.
- Sampling is a per-word snapshot at SAMPLE. Data memory may change during the frame; each byte reflects memory at its own sample cycle.
- start while busy=1 is ignored and not queued. start in the FINISH cycle is also ignored.
- The address counter does not wrap within a frame. The last-address test uses the full DM_ADDR_W compare.
- UART serialiser:
  - 8N1, LSB first.
  - Start bit 0 for CLKS_PER_BIT cycles, then 8 data bits of CLKS_PER_BIT cycles each, then stop bit 1 for CLKS_PER_BIT cycles.
  - tx_done pulses on the last cycle of the stop bit.
  - A tx_start while the serialiser is busy is a protocol error and cannot occur by FSM construction. The serialiser ignores it.
- Latency:
  - start sampled at edge N; tx falls (header start bit) at edge N+2.
  - Each data byte adds 2 gap cycles (SET_ADDR, SAMPLE) plus 1 tx_start cycle between bytes.

Decomposition:
- Package dm_dump_pkg:
  - FSM state enum.
  - HEADER_BYTE default.
  - UART frame constants: DATA_BITS=8, start bit, stop bit.
- Sub-module uart_tx: serialiser with a baud counter and bit counter.
  - Ports: clk, reset, tx_start, tx_data[7:0], tx, tx_busy, tx_done.
  - Instantiated once. dm_uart_dumper holds the address/checksum FSM.

Test Plan:
- Bit timing, CLKS_PER_BIT=4, memory all zero, pulse start:
  - tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 (0xA5 LSB first) at 4 cycles each, then high 4 cycles.
  - Decoded frame: A5, 00×16, 00; done pulses once; busy drops the same cycle.
- Memory word[i]=17*i (00,11,…,FF): frame is A5, 00,11,22,…,FF, F8. addr_on_dm observed stepping 0..15, then back to 0.
- Checksum wrap, memory all FF: checksum byte is F0 (4080 mod 256).
- start re-pulsed at the 3rd data byte: frame unaffected, exactly one done pulse, no second frame.
- reset asserted mid-word 5: next cycle tx=1, busy=0, addr_on_dm=0. A fresh start afterwards produces a complete correct 18-byte frame.
- Model word[7] changed from 0x00 to 0x3C while word 3 is being sent: the dump shows word[7]=3C, and the checksum includes 3C.

Source files
------------

// File: rtl/dm_dump_pkg.sv
// Shared types and constants for the data-memory UART dumper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dm_dump_pkg;

    // Top-level sweep/transmit sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_HDR,
        ST_SET_ADDR,
        ST_SAMPLE,
        ST_SEND_DATA,
        ST_SEND_SUM,
        ST_FINISH
    } dump_state_e;

    // Marker byte opening every dump frame
    localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

    // 8N1 character framing
    localparam int unsigned DATA_BITS  = 8;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;
    localparam int unsigned FRAME_BITS = DATA_BITS + 2;

endpackage

// File: rtl/dm_uart_dumper_uart_tx.sv
// 8N1 UART serialiser, LSB first, CLKS_PER_BIT clocks per bit.
// Latency: tx drives the start bit on the edge that samples tx_start.
// Backpressure: tx_start is ignored while tx_busy; tx_done marks the last stop-bit cycle.
module uart_tx
    import dm_dump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned       BAUD_W        = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
    // Bit slot index: 0 = start, 1..8 = data, 9 = stop
    localparam logic [3:0]        BIT_LAST      = 4'(FRAME_BITS - 1);
    localparam logic [3:0]        BIT_LAST_DATA = 4'(FRAME_BITS - 2);

    logic                 busy_q,  busy_d;
    logic [3:0]           bit_q,   bit_d;
    logic [BAUD_W-1:0]    baud_q,  baud_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q,    tx_d;

    // Next-state: load on start, then step through bit slots every CLKS_PER_BIT clocks
    always_comb begin
        busy_d  = busy_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        if (!busy_q) begin
            if (tx_start) begin
                busy_d  = 1'b1;
                bit_d   = 4'd0;
                baud_d  = '0;
                shreg_d = tx_data;
                tx_d    = START_BIT;
            end
        end else if (baud_q != BAUD_LAST) begin
            baud_d = baud_q + 1'b1;
        end else begin
            baud_d = '0;
            if (bit_q == BIT_LAST) begin
                busy_d = 1'b0;
            end else begin
                bit_d = bit_q + 4'd1;
                if (bit_q == BIT_LAST_DATA) begin
                    tx_d = STOP_BIT;
                end else begin
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
        end
    end

    // State registers; line idles high out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            bit_q   <= 4'd0;
            baud_q  <= '0;
            shreg_q <= '0;
            tx_q    <= STOP_BIT;
        end else begin
            busy_q  <= busy_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = busy_q && (bit_q == BIT_LAST) && (baud_q == BAUD_LAST);

endmodule

// File: rtl/dm_uart_dumper.sv
// Sweeps the data-memory debug port and streams header, every word and a checksum over UART.
// Latency: start sampled at edge N gives the header start bit at edge N+2.
// Backpressure: start is dropped unless idle; each byte waits for the serialiser's tx_done.
module dm_uart_dumper
    import dm_dump_pkg::*;
#(
    parameter int unsigned DM_ADDR_W    = 4,
    parameter int unsigned DM_DATA_W    = 8,   // must match the UART byte width
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  HEADER_BYTE  = HEADER_BYTE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [DM_ADDR_W-1:0] addr_on_dm,
    input  logic [DM_DATA_W-1:0] data_on_dm,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [DM_ADDR_W-1:0] ADDR_LAST = '1;

    dump_state_e          state_q, state_d;
    logic [DM_ADDR_W-1:0] addr_q,  addr_d;
    logic [DM_DATA_W-1:0] sum_q,   sum_d;
    logic [DM_DATA_W-1:0] byte_q,  byte_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic                 pend_q,  pend_d;   // start accepted, header launch next cycle

    logic                 tx_start;
    logic [DM_DATA_W-1:0] tx_data;
    logic                 utx_busy;
    logic                 utx_done;

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (utx_busy),
        .tx_done  (utx_done)
    );

    // Sequencer: next state, address/checksum updates and serialiser launch
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sum_d    = sum_q;
        byte_d   = byte_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pend_d   = 1'b0;
        tx_start = 1'b0;
        tx_data  = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_SEND_HDR;
                end else if (start) begin
                    pend_d = 1'b1;
                    busy_d = 1'b1;
                end
            end
            ST_SEND_HDR: begin
                tx_data  = HEADER_BYTE;
                tx_start = !utx_busy;
                if (utx_done) begin
                    state_d = ST_SET_ADDR;
                    addr_d  = '0;
                end
            end
            // Address held one cycle so the combinational read settles
            ST_SET_ADDR: state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                byte_d  = data_on_dm;
                sum_d   = sum_q + data_on_dm;
                state_d = ST_SEND_DATA;
            end
            ST_SEND_DATA: begin
                tx_start = !utx_busy;
                if (utx_done) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = ST_SEND_SUM;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_SET_ADDR;
                    end
                end
            end
            ST_SEND_SUM: begin
                tx_data  = sum_q;
                tx_start = !utx_busy;
                if (utx_done) begin
                    state_d = ST_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    addr_d  = '0;
                    sum_d   = '0;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            sum_q   <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            byte_q  <= byte_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

    assign addr_on_dm = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
